debounce_filter: RTL
====================

// Module: debounce_filter
// PURPOSE
//  Multi-channel counter-based debouncer for mechanical keys and buttons.
//  Each channel is synchronised, then its output changes only after the new level has held for STABLE_COUNT tick-qualified cycles.
//  Each channel also produces one-cycle rise and fall strobes.
//  Sits between raw pad/keypad inputs and the consuming logic (keypad scanner, reset/menu buttons).
// PARAMETERS
//  WIDTH         1      number of independent channels
//  SYNC_STAGES   2      synchroniser flops per channel (>=2)
//  STABLE_COUNT  50000  tick-qualified cycles a new level must persist (>=1)
//  CNT_W         16     per-channel counter width; STABLE_COUNT <= 2**CNT_W - 1
//  INIT          0      reset level of every synchroniser stage and out bit (1-bit)
// PORTS
//  clk   input   1      system clock, all logic on rising edge
//  rst   input   1      synchronous, active-high reset
//  tick  input   1      count enable / prescaler strobe; tie 1 to count every clk
//  in    input   WIDTH  raw asynchronous inputs
//  out   output  WIDTH  debounced levels (registered)
//  rise  output  WIDTH  1-cycle strobe: out[i] went 0->1 this cycle
//  fall  output  WIDTH  1-cycle strobe: out[i] went 1->0 this cycle
// BEHAVIOUR
//  - Reset (rst=1 at clk edge):
//    - all sync stages and out = {WIDTH{INIT}}; counters = 0; rise = fall = 0.
//    - Reset overrides all other activity, including mid-count.
//    - No strobes on reset release.
//  - Per channel i (fully independent, no shared state):
//    - sync chain: s[0] <= in[i], s[k] <= s[k-1]; s_q = s[SYNC_STAGES-1].
//    - If s_q == out[i]: cnt <= 0. This applies regardless of tick, so any bounce restarts the count.
//    - Else if tick=0: cnt holds.
//    - Else if cnt == STABLE_COUNT-1:
//      - out[i] <= s_q; cnt <= 0;
//      - rise[i] <= s_q; fall[i] <= ~s_q.
//    - Else: cnt <= cnt + 1.
//  - rise/fall: default 0 every cycle. Asserted in the same cycle out[i] takes its new value; never both high.
//  - Latency (tick=1 constantly): new level sampled at edge E0. out[i] changes at edge E0+SYNC_STAGES+STABLE_COUNT-1.
//  - STABLE_COUNT=1: out follows s_q one cycle later, with no filtering.
//  - Counter never wraps: it is cleared at STABLE_COUNT-1 or on a match.
//  - A pulse of fewer than STABLE_COUNT tick-qualified cycles at s_q has no effect on out.
//  - Simultaneous events across channels are independent; multiple rise/fall bits may be set in one cycle.
// TESTING
//  (bench params: WIDTH=2, SYNC_STAGES=2, STABLE_COUNT=4, INIT=0, tick=1 unless stated)
//  1. rst 2 cycles, then in=2'b01 from edge E0
//     -> out=2'b01 at E0+5; rise=2'b01 for exactly that cycle; fall=0 throughout.
//  2. in[0]=1 for 3 cycles, then 0
//     -> out stays 2'b00; rise/fall never assert.
//  3. in[0] toggles 1,0,1,0,1 at edges E0..E4, then held 1
//     -> out[0] rises at E4+5 only; exactly one rise pulse.
//  4. tick high every 3rd clk, in[1]=1 held
//     -> out[1] rises on the 4th tick-high cycle after s_q goes high; count holds between ticks.
//  5. in[0]=1 held; assert rst when cnt=3
//     -> out=0, no strobe. After release with in[0] still 1: out[0] rises SYNC_STAGES+STABLE_COUNT-1 edges after the first post-reset sampling edge (full recount).
//  6. out=2'b10 settled, then in=2'b01 at one edge
//     -> rise=2'b01 and fall=2'b10 in the same cycle; out=2'b01.

Source files
------------

// File: rtl/debounce_filter.sv
// Multi-channel counter-based debouncer: each input is synchronised, then its
// debounced level changes only after the new level holds for STABLE_COUNT ticks.
module debounce_filter #(
    parameter int   WIDTH        = 1,
    parameter int   SYNC_STAGES  = 2,
    parameter int   STABLE_COUNT = 50000,
    parameter int   CNT_W        = 16,
    parameter logic INIT         = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_COUNT - 1);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [CNT_W-1:0] cnt_q  [WIDTH];
    logic [CNT_W-1:0] cnt_d  [WIDTH];
    logic [WIDTH-1:0] out_q, out_d;
    logic [WIDTH-1:0] rise_q, rise_d;
    logic [WIDTH-1:0] fall_q, fall_d;
    logic [WIDTH-1:0] s_q;

    assign s_q = sync_q[SYNC_STAGES-1];

    always_comb begin
        // NOTE: every comb output gets a default first so no path leaves it unassigned (no latch).
        sync_d[0] = in;
        for (int k = 1; k < SYNC_STAGES; k++) begin
            sync_d[k] = sync_q[k-1];
        end
        out_d  = out_q;
        rise_d = '0;
        fall_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_d[i] = cnt_q[i];
            // A match clears the count even without a tick, so any bounce restarts it.
            if (s_q[i] == out_q[i]) begin
                cnt_d[i] = '0;
            end else if (tick) begin
                if (cnt_q[i] == CNT_LAST) begin
                    out_d[i]  = s_q[i];
                    rise_d[i] = s_q[i];
                    fall_d[i] = ~s_q[i];
                    cnt_d[i]  = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= {WIDTH{INIT}};
            end
            for (int i = 0; i < WIDTH; i++) begin
                cnt_q[i] <= '0;
            end
            out_q  <= {WIDTH{INIT}};
            rise_q <= '0;
            fall_q <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule
